// File: rtl/dm_pkg.sv
// Shared types and constants for the dm_bank data memory.
// Lane-enable encodings match the requester's req_wea bit-per-byte convention.
package dm_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } dm_state_e;

    localparam logic [3:0] WEA_NONE    = 4'b0000;
    localparam logic [3:0] WEA_WORD    = 4'b1111;
    localparam logic [3:0] WEA_HALF_LO = 4'b0011;
    localparam logic [3:0] WEA_HALF_HI = 4'b1100;
    localparam logic [3:0] WEA_B0      = 4'b0001;
    localparam logic [3:0] WEA_B1      = 4'b0010;
    localparam logic [3:0] WEA_B2      = 4'b0100;
    localparam logic [3:0] WEA_B3      = 4'b1000;

    // One read-response beat travelling down the latency pipe.
    typedef struct packed {
        logic        err;
        logic [31:0] dat;
    } rd_beat_t;

    function automatic logic is_write(input logic [3:0] wea);
        return wea != WEA_NONE;
    endfunction

endpackage

// File: rtl/dm_rd_pipe.sv
// Purpose: delays read responses by STAGES cycles behind the RAM output register.
// Latency: STAGES cycles; payload only moves with a valid so the last value is held.
// Backpressure: none, every stage advances every cycle; async reset clears valids only.
module dm_rd_pipe
    import dm_pkg::*;
#(
    parameter int STAGES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_vld,
    input  logic        in_err,
    input  logic [31:0] in_dat,
    output logic        out_vld,
    output logic        out_err,
    output logic [31:0] out_dat
);

    logic [STAGES-1:0] vld_q, vld_d;
    rd_beat_t          beat_q [STAGES];
    rd_beat_t          beat_d [STAGES];

    always_comb begin
        vld_d[0]  = in_vld;
        beat_d[0] = in_vld ? '{err: in_err, dat: in_dat} : beat_q[0];
        for (int i = 1; i < STAGES; i++) begin
            vld_d[i]  = vld_q[i-1];
            beat_d[i] = vld_q[i-1] ? beat_q[i-1] : beat_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        beat_q <= beat_d;
    end

    assign out_vld = vld_q[STAGES-1];
    assign out_err = beat_q[STAGES-1].err;
    assign out_dat = beat_q[STAGES-1].dat;

endmodule

// File: rtl/dm_bank.sv
// Purpose: word-organised data memory with lane writes, zero-fill after reset; DM_BOUNDS_CHECK_EN adds range check.
// Latency: reads answered READ_LATENCY cycles after accept, in order; writes produce no response.
// Backpressure: req_ready low only while the post-reset clear sequence runs; one request per cycle otherwise.
module dm_bank
    import dm_pkg::*;
#(
    parameter int ADDR_WIDTH   = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_wea,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    dm_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                  rd_vld_q, rd_vld_d;
    logic                  rd_err_q, rd_err_d;
    logic [31:0]           rd_dat_q, rd_dat_d;

    logic [31:0]           mem [DEPTH];
    logic                  mem_we;
    logic [3:0]            mem_be;
    logic [ADDR_WIDTH-1:0] mem_idx;
    logic [31:0]           mem_wdat;

    logic [ADDR_WIDTH-1:0] req_idx;
    logic                  oor;
    logic                  unused_addr;

    assign req_idx = req_addr[ADDR_WIDTH+1:2];

`ifdef DM_BOUNDS_CHECK_EN
    assign oor         = |req_addr[31:ADDR_WIDTH+2];
    assign unused_addr = ^req_addr[1:0];
`else
    assign oor         = 1'b0;
    assign unused_addr = ^{req_addr[31:ADDR_WIDTH+2], req_addr[1:0]};
`endif

    assign req_ready = (state_q == READY);

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        rd_vld_d  = 1'b0;
        rd_err_d  = rd_err_q;
        rd_dat_d  = rd_dat_q;
        mem_we    = 1'b0;
        mem_be    = req_wea;
        mem_idx   = req_idx;
        mem_wdat  = req_wdata;
        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_be    = WEA_WORD;
                mem_idx   = clr_cnt_q;
                mem_wdat  = '0;
                clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
                if (&clr_cnt_q) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (req_valid) begin
                    if (is_write(req_wea)) begin
                        mem_we = !oor;
                    end else begin
                        // Sampled before this edge's write lands; single port, so no same-edge hazard.
                        rd_vld_d = 1'b1;
                        rd_err_d = oor;
                        rd_dat_d = oor ? 32'h0 : mem[req_idx];
                    end
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            rd_vld_q  <= 1'b0;
            rd_err_q  <= 1'b0;
            rd_dat_q  <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rd_vld_q  <= rd_vld_d;
            rd_err_q  <= rd_err_d;
            rd_dat_q  <= rd_dat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) begin
                    mem[mem_idx][8*i +: 8] <= mem_wdat[8*i +: 8];
                end
            end
        end
    end

    generate
        if (READ_LATENCY > 1) begin : g_pipe
            logic        p_vld, p_err;
            logic [31:0] p_dat;
            logic        seen_q, seen_d;

            dm_rd_pipe #(
                .STAGES (READ_LATENCY - 1)
            ) u_rd_pipe (
                .clk     (clk),
                .rst     (rst),
                .in_vld  (rd_vld_q),
                .in_err  (rd_err_q),
                .in_dat  (rd_dat_q),
                .out_vld (p_vld),
                .out_err (p_err),
                .out_dat (p_dat)
            );

            // Pipe payload is not reset; present zero until the first response after reset.
            always_comb seen_d = seen_q | p_vld;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    seen_q <= 1'b0;
                end else begin
                    seen_q <= seen_d;
                end
            end

            assign rsp_valid = p_vld;
            assign rsp_rdata = seen_d ? p_dat : 32'h0;
            assign rsp_err   = seen_d ? p_err : 1'b0;
        end else begin : g_direct
            assign rsp_valid = rd_vld_q;
            assign rsp_rdata = rd_dat_q;
            assign rsp_err   = rd_err_q;
        end
    endgenerate

endmodule

// File: tb/tb_dm_bank.sv
// Directed bench: two dm_bank instances (latency 1 and 3, 16 words) share one request stream.
module tb_dm_bank;
    import dm_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [3:0]  req_wea;
    logic [31:0] req_wdata;

    logic        rdy1, v1, e1;
    logic [31:0] d1;
    logic        rdy3, v3, e3;
    logic [31:0] d3;

    int checks = 0;
    int passed = 0;

    dm_bank #(.ADDR_WIDTH(4), .READ_LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1),
        .req_addr(req_addr), .req_wea(req_wea), .req_wdata(req_wdata),
        .rsp_valid(v1), .rsp_rdata(d1), .rsp_err(e1)
    );

    dm_bank #(.ADDR_WIDTH(4), .READ_LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy3),
        .req_addr(req_addr), .req_wea(req_wea), .req_wdata(req_wdata),
        .rsp_valid(v3), .rsp_rdata(d3), .rsp_err(e3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        chk({tag, "_rdy_low"}, {31'b0, rdy1}, 32'd0);
        while (!rdy1 && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_clear_cycles"}, n, 32'd16);
        chk({tag, "_rdy3"}, {31'b0, rdy3}, 32'd1);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] wea, input logic [31:0] wdata);
        req_valid = 1'b1;
        req_addr  = addr;
        req_wea   = wea;
        req_wdata = wdata;
        tick();
        req_valid = 1'b0;
        req_wea   = WEA_NONE;
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp_d,
                      input logic exp_e);
        req_valid = 1'b1;
        req_addr  = addr;
        req_wea   = WEA_NONE;
        req_wdata = 32'h0;
        tick();
        req_valid = 1'b0;
        chk({tag, "_l1_vld"}, {31'b0, v1}, 32'd1);
        chk({tag, "_l1_dat"}, d1, exp_d);
        chk({tag, "_l1_err"}, {31'b0, e1}, {31'b0, exp_e});
        chk({tag, "_l3_early0"}, {31'b0, v3}, 32'd0);
        tick();
        chk({tag, "_l1_pulse"}, {31'b0, v1}, 32'd0);
        chk({tag, "_l3_early1"}, {31'b0, v3}, 32'd0);
        tick();
        chk({tag, "_l3_vld"}, {31'b0, v3}, 32'd1);
        chk({tag, "_l3_dat"}, d3, exp_d);
        chk({tag, "_l3_err"}, {31'b0, e3}, {31'b0, exp_e});
        tick();
        chk({tag, "_l3_pulse"}, {31'b0, v3}, 32'd0);
        chk({tag, "_l3_hold"}, d3, exp_d);
        chk({tag, "_l1_hold"}, d1, exp_d);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rdy1"}, {31'b0, rdy1}, 32'd0);
        chk({tag, "_v1"},   {31'b0, v1},   32'd0);
        chk({tag, "_d1"},   d1,            32'd0);
        chk({tag, "_e1"},   {31'b0, e1},   32'd0);
        chk({tag, "_rdy3"}, {31'b0, rdy3}, 32'd0);
        chk({tag, "_v3"},   {31'b0, v3},   32'd0);
        chk({tag, "_d3"},   d3,            32'd0);
        chk({tag, "_e3"},   {31'b0, e3},   32'd0);
    endtask

    initial begin
        logic [31:0] w0, w1, w2, w_hi;
        logic        e_hi;
        int          stray;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = 32'h0;
        req_wea   = WEA_NONE;
        req_wdata = 32'h0;

        // 1: reset state, clear sequence, cleared word reads zero
        repeat (3) tick();
        chk_reset_outputs("rst");
        rst = 1'b0;
        wait_clear("clr1");
        rd("rd_zero", 32'h0000_000C, 32'h0, 1'b0);

        // 2: full-word write then read on the very next cycle
        wr(32'h0000_0008, WEA_WORD, 32'hDEAD_BEEF);
        rd("rd_after_wr", 32'h0000_0008, 32'hDEAD_BEEF, 1'b0);

        // 3: partial lane writes leave other lanes untouched; addr[1:0] ignored
        wr(32'h0000_000A, WEA_B2, 32'h5555_5555);
        wr(32'h0000_0009, WEA_HALF_LO, 32'h1234_1234);
        rd("rd_lanes", 32'h0000_000B, 32'hDE55_1234, 1'b0);

        // 4: back-to-back reads return in order on consecutive cycles
        w0 = 32'h0A0A_0A0A;
        w1 = 32'h0B0B_0B0B;
        w2 = 32'hDE55_1234;
        wr(32'h0000_0000, WEA_WORD, w0);
        wr(32'h0000_0004, WEA_WORD, w1);
        req_valid = 1'b1;
        req_wea   = WEA_NONE;
        req_addr  = 32'h0000_0000;
        tick();
        chk("b2b_l1_r0", d1, w0);
        chk("b2b_l1_v0", {31'b0, v1}, 32'd1);
        req_addr = 32'h0000_0004;
        tick();
        chk("b2b_l1_r1", d1, w1);
        req_addr = 32'h0000_0008;
        tick();
        req_valid = 1'b0;
        chk("b2b_l1_r2", d1, w2);
        chk("b2b_l3_v0", {31'b0, v3}, 32'd1);
        chk("b2b_l3_r0", d3, w0);
        tick();
        chk("b2b_l1_idle", {31'b0, v1}, 32'd0);
        chk("b2b_l3_v1", {31'b0, v3}, 32'd1);
        chk("b2b_l3_r1", d3, w1);
        tick();
        chk("b2b_l3_v2", {31'b0, v3}, 32'd1);
        chk("b2b_l3_r2", d3, w2);
        tick();
        chk("b2b_l3_idle", {31'b0, v3}, 32'd0);

        // 5: reset with reads in flight drops them and re-clears memory
        req_valid = 1'b1;
        req_addr  = 32'h0000_0008;
        tick();
        req_addr  = 32'h0000_0000;
        tick();
        req_valid = 1'b0;
        rst       = 1'b1;
        #1;
        chk_reset_outputs("rst2");
        stray = 0;
        repeat (4) begin
            tick();
            if (v1 || v3) stray++;
        end
        chk("rst2_no_rsp", stray, 32'd0);
        rst = 1'b0;
        stray = 0;
        repeat (3) begin
            if (v3) stray++;
            tick();
        end
        chk("rst2_no_late_rsp", stray, 32'd0);
        while (!rdy1) tick();
        chk("rst2_rdy3", {31'b0, rdy3}, 32'd1);
        rd("rd_recleared", 32'h0000_0008, 32'h0, 1'b0);

        // 6: address beyond the array
        wr(32'h0000_0000, WEA_WORD, 32'h1111_2222);
        wr(32'h0000_0040, WEA_WORD, 32'hA5A5_A5A5);
`ifdef DM_BOUNDS_CHECK_EN
        w_hi = 32'h0;
        e_hi = 1'b1;
        w0   = 32'h1111_2222;
`else
        w_hi = 32'hA5A5_A5A5;
        e_hi = 1'b0;
        w0   = 32'hA5A5_A5A5;
`endif
        rd("rd_hi", 32'h0000_0040, w_hi, e_hi);
        rd("rd_word0", 32'h0000_0000, w0, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no completion expected finish before 200000");
        $fatal(1);
    end

endmodule
